// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants and holding-entry record for the register-file write arbiter.
package rf_write_arbiter_pkg;

    localparam int unsigned N_DEF            = 32;
    localparam int unsigned ADDRESS_SIZE_DEF = 6;

    localparam logic CH_A = 1'b0;
    localparam logic CH_B = 1'b1;

    typedef struct packed {
        logic                        valid;
        logic [ADDRESS_SIZE_DEF-1:0] address;
        logic [N_DEF-1:0]            data;
    } hold_entry_t;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Writeback request channels, register-file write port and hazard query bundle.
interface rf_write_arbiter_if
    import rf_write_arbiter_pkg::*;
#(
    parameter int unsigned N            = N_DEF,
    parameter int unsigned ADDRESS_SIZE = ADDRESS_SIZE_DEF
) ();

    logic                    a_valid;
    logic                    a_ready;
    logic [ADDRESS_SIZE-1:0] a_address;
    logic [N-1:0]            a_data;

    logic                    b_valid;
    logic                    b_ready;
    logic [ADDRESS_SIZE-1:0] b_address;
    logic [N-1:0]            b_data;

    logic                    rf_write;
    logic [ADDRESS_SIZE-1:0] rf_rd_address;
    logic [N-1:0]            rf_write_data;

    logic [ADDRESS_SIZE-1:0] rs_address;
    logic [ADDRESS_SIZE-1:0] rt_address;
    logic                    rs_pending;
    logic                    rt_pending;

    modport master (
        output a_valid, a_address, a_data,
        output b_valid, b_address, b_data,
        output rs_address, rt_address,
        input  a_ready, b_ready,
        input  rf_write, rf_rd_address, rf_write_data,
        input  rs_pending, rt_pending
    );

    modport slave (
        input  a_valid, a_address, a_data,
        input  b_valid, b_address, b_data,
        input  rs_address, rt_address,
        output a_ready, b_ready,
        output rf_write, rf_rd_address, rf_write_data,
        output rs_pending, rt_pending
    );

endinterface

// File: rtl/rf_write_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter: combinational grant, pointer holds the last granted channel.
module rr_arbiter2
    import rf_write_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] grant_c
);

    logic last_q;

    // Contention goes to the channel not granted most recently.
    always_comb begin
        grant_c = req;
        if (req[CH_A] && req[CH_B]) begin
            grant_c = '0;
            if (last_q == CH_B) grant_c[CH_A] = 1'b1;
            else                grant_c[CH_B] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= CH_B;
        end else if (grant_c[CH_A]) begin
            last_q <= CH_A;
        end else if (grant_c[CH_B]) begin
            last_q <= CH_B;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Merges integer and FPU writebacks onto one register-file write port.
// Optional per-address pending scoreboard: define RF_WR_ARB_SCOREBOARD_EN.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int unsigned N            = N_DEF,
    parameter int unsigned ADDRESS_SIZE = ADDRESS_SIZE_DEF
) (
    input logic              clk,
    input logic              reset,
    rf_write_arbiter_if.slave bus
);

    typedef struct packed {
        logic                    valid;
        logic [ADDRESS_SIZE-1:0] address;
        logic [N-1:0]            data;
    } entry_t;

    entry_t                  hold_a_q;
    entry_t                  hold_b_q;
    logic [1:0]              grant_c;
    logic                    acc_a;
    logic                    acc_b;
    logic                    rf_write_q;
    logic [ADDRESS_SIZE-1:0] rf_rd_address_q;
    logic [N-1:0]            rf_write_data_q;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     ({hold_b_q.valid, hold_a_q.valid}),
        .grant_c (grant_c)
    );

    // A holding register can refill on the same edge it drains.
    assign bus.a_ready = !hold_a_q.valid || grant_c[CH_A];
    assign bus.b_ready = !hold_b_q.valid || grant_c[CH_B];
    assign acc_a       = bus.a_valid && bus.a_ready;
    assign acc_b       = bus.b_valid && bus.b_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_a_q <= '0;
        end else if (acc_a) begin
            hold_a_q <= '{valid: 1'b1, address: bus.a_address, data: bus.a_data};
        end else if (grant_c[CH_A]) begin
            hold_a_q.valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_b_q <= '0;
        end else if (acc_b) begin
            hold_b_q <= '{valid: 1'b1, address: bus.b_address, data: bus.b_data};
        end else if (grant_c[CH_B]) begin
            hold_b_q.valid <= 1'b0;
        end
    end

    // Write port: address/data hold their last value on idle cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_write_q      <= 1'b0;
            rf_rd_address_q <= '0;
            rf_write_data_q <= '0;
        end else begin
            rf_write_q <= |grant_c;
            if (grant_c[CH_A]) begin
                rf_rd_address_q <= hold_a_q.address;
                rf_write_data_q <= hold_a_q.data;
            end else if (grant_c[CH_B]) begin
                rf_rd_address_q <= hold_b_q.address;
                rf_write_data_q <= hold_b_q.data;
            end
        end
    end

    assign bus.rf_write      = rf_write_q;
    assign bus.rf_rd_address = rf_rd_address_q;
    assign bus.rf_write_data = rf_write_data_q;

`ifdef RF_WR_ARB_SCOREBOARD_EN
    localparam int unsigned DEPTH = 2 ** ADDRESS_SIZE;

    logic [1:0] pend_q [DEPTH];
    logic [1:0] pend_d [DEPTH];

    // Up to three outstanding writes per address: two holdings plus the write port.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            pend_d[i] = pend_q[i]
                      + 2'(acc_a && (bus.a_address == ADDRESS_SIZE'(i)))
                      + 2'(acc_b && (bus.b_address == ADDRESS_SIZE'(i)))
                      - 2'(rf_write_q && (rf_rd_address_q == ADDRESS_SIZE'(i)));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) pend_q[i] <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign bus.rs_pending = (pend_q[bus.rs_address] != 2'd0);
    assign bus.rt_pending = (pend_q[bus.rt_address] != 2'd0);
`else
    logic unused_query;
    assign unused_query   = ^{bus.rs_address, bus.rt_address};
    assign bus.rs_pending = 1'b0;
    assign bus.rt_pending = 1'b0;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter (either scoreboard build).
module tb_rf_write_arbiter;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fails;

`ifdef RF_WR_ARB_SCOREBOARD_EN
    localparam logic [63:0] PEND = 64'd1;
`else
    localparam logic [63:0] PEND = 64'd0;
`endif

    rf_write_arbiter_if #(.N(32), .ADDRESS_SIZE(6)) bus ();

    rf_write_arbiter #(.N(32), .ADDRESS_SIZE(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [5:0] addr, input logic [31:0] d);
        bus.a_valid   = v;
        bus.a_address = addr;
        bus.a_data    = d;
    endtask

    task automatic drive_b(input logic v, input logic [5:0] addr, input logic [31:0] d);
        bus.b_valid   = v;
        bus.b_address = addr;
        bus.b_data    = d;
    endtask

    task automatic check_wr(input string tag, input logic [63:0] addr, input logic [63:0] d);
        check({tag, "_wr"},   64'(bus.rf_write), 64'd1);
        check({tag, "_addr"}, 64'(bus.rf_rd_address), addr);
        check({tag, "_data"}, 64'(bus.rf_write_data), d);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset    = 1'b0;
        drive_a(1'b0, 6'd0, 32'd0);
        drive_b(1'b0, 6'd0, 32'd0);
        bus.rs_address = 6'd0;
        bus.rt_address = 6'd0;

        // Reset state
        #1;
        check("rst_wr",    64'(bus.rf_write), 64'd0);
        check("rst_addr",  64'(bus.rf_rd_address), 64'd0);
        check("rst_data",  64'(bus.rf_write_data), 64'd0);
        check("rst_rdy_a", 64'(bus.a_ready), 64'd1);
        check("rst_rdy_b", 64'(bus.b_ready), 64'd1);
        check("rst_pend",  64'(bus.rs_pending), 64'd0);
        step();
        reset = 1'b1;
        check("rel_rdy_a", 64'(bus.a_ready), 64'd1);
        check("rel_rdy_b", 64'(bus.b_ready), 64'd1);

        // Single request on A, address 5
        drive_a(1'b1, 6'd5, 32'h1234);
        bus.rs_address = 6'd5;
        step();
        drive_a(1'b0, 6'd0, 32'd0);
        check("single_e0_wr",   64'(bus.rf_write), 64'd0);
        check("single_e0_pend", 64'(bus.rs_pending), PEND);
        check("single_e0_rdy",  64'(bus.a_ready), 64'd1);
        step();
        check_wr("single_e1", 64'd5, 64'h1234);
        check("single_e1_pend", 64'(bus.rs_pending), PEND);
        step();
        check("single_e2_wr",   64'(bus.rf_write), 64'd0);
        check("single_e2_pend", 64'(bus.rs_pending), 64'd0);
        check("single_e2_hold", 64'(bus.rf_write_data), 64'h1234);

        // Address 0 through B is written like any other
        drive_b(1'b1, 6'd0, 32'hDEAD);
        step();
        drive_b(1'b0, 6'd0, 32'd0);
        step();
        check_wr("addr0", 64'd0, 64'hDEAD);
        step();
        check("addr0_idle", 64'(bus.rf_write), 64'd0);

        // Contention after reset: A first
        pulse_reset();
        drive_a(1'b1, 6'd3, 32'hAAAA);
        drive_b(1'b1, 6'd4, 32'hBBBB);
        step();
        drive_a(1'b0, 6'd0, 32'd0);
        drive_b(1'b0, 6'd0, 32'd0);
        check("cont1_rdy_a", 64'(bus.a_ready), 64'd1);
        check("cont1_rdy_b", 64'(bus.b_ready), 64'd0);
        step();
        check_wr("cont1_first", 64'd3, 64'hAAAA);
        step();
        check_wr("cont1_second", 64'd4, 64'hBBBB);
        step();
        check("cont1_idle", 64'(bus.rf_write), 64'd0);

        // Solo A moves the pointer to A, so the next contention goes to B
        drive_a(1'b1, 6'd1, 32'h11);
        step();
        drive_a(1'b0, 6'd0, 32'd0);
        step();
        check_wr("solo_a", 64'd1, 64'h11);
        step();
        drive_a(1'b1, 6'd3, 32'hA2);
        drive_b(1'b1, 6'd4, 32'hB2);
        step();
        drive_a(1'b0, 6'd0, 32'd0);
        drive_b(1'b0, 6'd0, 32'd0);
        check("cont2_rdy_a", 64'(bus.a_ready), 64'd0);
        check("cont2_rdy_b", 64'(bus.b_ready), 64'd1);
        step();
        check_wr("cont2_first", 64'd4, 64'hB2);
        step();
        check_wr("cont2_second", 64'd3, 64'hA2);
        step();
        check("cont2_idle", 64'(bus.rf_write), 64'd0);

        // Eight back-to-back A requests, B idle
        for (int i = 0; i < 10; i++) begin
            if (i < 8) drive_a(1'b1, 6'(8 + i), 32'(256 + i));
            else       drive_a(1'b0, 6'd0, 32'd0);
            check("b2b_rdy", 64'(bus.a_ready), 64'd1);
            step();
            check("b2b_wr", 64'(bus.rf_write), 64'((i >= 1) && (i <= 8)));
            if ((i >= 1) && (i <= 8)) begin
                check("b2b_addr", 64'(bus.rf_rd_address), 64'(7 + i));
                check("b2b_data", 64'(bus.rf_write_data), 64'(255 + i));
            end
        end

        // Same address 7 from both channels, pointer = B after reset
        pulse_reset();
        drive_a(1'b1, 6'd7, 32'h1);
        drive_b(1'b1, 6'd7, 32'h2);
        bus.rs_address = 6'd7;
        bus.rt_address = 6'd7;
        step();
        drive_a(1'b0, 6'd0, 32'd0);
        drive_b(1'b0, 6'd0, 32'd0);
        check("same_e0_rs", 64'(bus.rs_pending), PEND);
        check("same_e0_rt", 64'(bus.rt_pending), PEND);
        step();
        check_wr("same_e1", 64'd7, 64'h1);
        check("same_e1_rs", 64'(bus.rs_pending), PEND);
        step();
        check_wr("same_e2", 64'd7, 64'h2);
        check("same_e2_rs", 64'(bus.rs_pending), PEND);
        step();
        check("same_e3_wr", 64'(bus.rf_write), 64'd0);
        check("same_e3_rs", 64'(bus.rs_pending), 64'd0);
        check("same_e3_rt", 64'(bus.rt_pending), 64'd0);
        check("same_e3_data", 64'(bus.rf_write_data), 64'h2);

        // Reset while both holding registers are full
        drive_a(1'b1, 6'd9, 32'h99);
        drive_b(1'b1, 6'd10, 32'h98);
        bus.rs_address = 6'd9;
        bus.rt_address = 6'd10;
        step();
        drive_a(1'b0, 6'd0, 32'd0);
        drive_b(1'b0, 6'd0, 32'd0);
        check("full_rdy_b", 64'(bus.b_ready), 64'd0);
        reset = 1'b0;
        #1;
        check("midrst_rdy_a", 64'(bus.a_ready), 64'd1);
        check("midrst_rdy_b", 64'(bus.b_ready), 64'd1);
        check("midrst_rs",    64'(bus.rs_pending), 64'd0);
        step();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("postrst_wr",    64'(bus.rf_write), 64'd0);
            check("postrst_rdy_a", 64'(bus.a_ready), 64'd1);
            check("postrst_rdy_b", 64'(bus.b_ready), 64'd1);
            check("postrst_rs",    64'(bus.rs_pending), 64'd0);
            check("postrst_rt",    64'(bus.rt_pending), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
